// File: rtl/rst_req_pkg.sv
// Shared types for the reset-request generator.
//   cause_t     : sticky reset cause code as seen by firmware
//   rst_state_t : request FSM states
//   cnt_width() : width needed to hold a counter value 0..max_val
package rst_req_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_WDT  = 2'b10,
    CAUSE_SW   = 2'b11
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_HOLDOFF = 2'b10
  } rst_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// rising-edge detect of the debounced level.
//   i_clk  : board clock
//   i_rst  : synchronous active-high reset
//   i_btn  : raw asynchronous button, active-high
//   o_evt  : registered 1-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce
  import rst_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_evt
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any bounce back to the accepted level restarts it.
  // It stops at CNT_LAST, so it never wraps.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    evt_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        evt_d = sync2_q;   // only the press edge is an event
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_evt = evt_q;

endmodule

// File: rtl/rst_req_gen.sv
// Reset-request generator: merges a debounced button, a software strobe and
// an optional watchdog into one stretched, registered reset request followed
// by a hold-off window. Firmware reads the last cause from o_cause.
//   i_clk        : board clock
//   i_rst        : board power-on reset, synchronous active-high
//   i_btn        : raw button, asynchronous active-high
//   i_sw_req     : 1-cycle software reset strobe
//   i_wdt_en     : watchdog enable
//   i_wdt_kick   : watchdog service strobe
//   i_wdt_limit  : watchdog timeout in cycles, 0 disables
//   o_rst_req    : reset request, PULSE_CYCLES wide
//   o_busy       : high during the request and the hold-off window
//   o_cause      : sticky cause (00 none, 01 button, 10 watchdog, 11 sw)
// Build option: define RST_REQ_WDT_EN to include the watchdog; otherwise the
// watchdog ports are ignored and cause 10 never occurs.
module rst_req_gen
  import rst_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 64,
  parameter int unsigned WDT_W           = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn,
  input  logic             i_sw_req,
  input  logic             i_wdt_en,
  input  logic             i_wdt_kick,
  input  logic [WDT_W-1:0] i_wdt_limit,
  output logic             o_rst_req,
  output logic             o_busy,
  output logic [1:0]       o_cause
);

  // One down-counter serves both the pulse and the hold-off phase.
  localparam int unsigned PCNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                                     PULSE_CYCLES - 1 : HOLDOFF_CYCLES - 1;
  localparam int unsigned       PCNT_W     = cnt_width(PCNT_MAX);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] HOLD_LOAD  = PCNT_W'(HOLDOFF_CYCLES - 1);

  rst_state_t        state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  cause_t            cause_q, cause_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              btn_evt;
  logic              wdt_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn),
    .o_evt (btn_evt)
  );

`ifdef RST_REQ_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;

  // A kick in the match cycle takes the clear branch, so it suppresses the
  // event. The counter saturates if the limit is moved below it.
  always_comb begin
    wdt_d   = wdt_q;
    wdt_evt = 1'b0;
    if (!i_wdt_en || i_wdt_kick || (state_q != ST_IDLE)) begin
      wdt_d = '0;
    end else if (i_wdt_limit != '0) begin
      if (wdt_q == i_wdt_limit) begin
        wdt_evt = 1'b1;
      end
      if (wdt_q != '1) begin
        wdt_d = wdt_q + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^{i_wdt_en, i_wdt_kick, i_wdt_limit};
  assign wdt_evt    = 1'b0;
`endif

  // Outputs are computed from the next state so they come straight out of
  // flops and change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cause_d = cause_q;
    req_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_evt || wdt_evt || i_sw_req) begin
          state_d = ST_ASSERT;
          pcnt_d  = PULSE_LOAD;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          if (btn_evt) begin
            cause_d = CAUSE_BTN;
          end else if (wdt_evt) begin
            cause_d = CAUSE_WDT;
          end else begin
            cause_d = CAUSE_SW;
          end
        end
      end
      ST_ASSERT: begin
        busy_d = 1'b1;
        if (pcnt_q == '0) begin
          state_d = ST_HOLDOFF;
          pcnt_d  = HOLD_LOAD;
        end else begin
          pcnt_d = pcnt_q - PCNT_W'(1);
          req_d  = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // Events are deliberately ignored here; nothing is queued.
        if (pcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pcnt_d = pcnt_q - PCNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      cause_q <= CAUSE_NONE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cause_q <= cause_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rst_req = req_q;
  assign o_busy    = busy_q;
  assign o_cause   = cause_q;

endmodule

// File: tb/tb_rst_req_gen.sv
module tb_rst_req_gen;

  localparam int DEB   = 8;
  localparam int PULSE = 16;
  localparam int HOLD  = 64;
  localparam int WDT_W = 24;

  logic             clk;
  logic             rst;
  logic             btn;
  logic             sw_req;
  logic             wdt_en;
  logic             wdt_kick;
  logic [WDT_W-1:0] wdt_limit;
  logic             rst_req;
  logic             busy;
  logic [1:0]       cause;

  rst_req_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PULSE),
    .HOLDOFF_CYCLES (HOLD),
    .WDT_W          (WDT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn      (btn),
    .i_sw_req   (sw_req),
    .i_wdt_en   (wdt_en),
    .i_wdt_kick (wdt_kick),
    .i_wdt_limit(wdt_limit),
    .o_rst_req  (rst_req),
    .o_busy     (busy),
    .o_cause    (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per expected request pulse.
  typedef struct {
    logic [1:0] cause;
    int         width;
  } exp_t;

  exp_t sb_q[$];
  int   pulse_cnt = 0;

  function automatic exp_t mk(input logic [1:0] c, input int w);
    exp_t e;
    e.cause = c;
    e.width = w;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t cur;
    bit   prev;
    int   w;
    prev = 1'b0;
    w    = 0;
    cur  = mk(2'b00, PULSE);
    forever begin
      @(negedge clk);
      if (rst_req && !prev) begin
        pulse_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
          cur = mk(cause, PULSE);
        end else begin
          cur = sb_q.pop_front();
          chk("pulse_cause", cause, cur.cause);
        end
        w = 1;
      end else if (rst_req) begin
        w++;
      end else if (prev) begin
        chk("pulse_width", w, cur.width);
      end
      prev = rst_req;
    end
  end

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic sw_strobe();
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    rst       = 1'b1;
    btn       = 1'b0;
    sw_req    = 1'b0;
    wdt_en    = 1'b0;
    wdt_kick  = 1'b0;
    wdt_limit = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_in_reset", rst_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cause", cause, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Software strobe: 16-cycle pulse, busy for 80 cycles in total.
    sb_q.push_back(mk(2'b11, PULSE));
    sw_strobe();
    chk("sw_latency", rst_req, 1);
    chk("sw_busy_rise", busy, 1);
    n = 1;
    repeat (99) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("sw_busy_len", n, PULSE + HOLD);
    chk("sw_cause", cause, 3);

    // Bouncing button then stable high: exactly one pulse, held 1000 cycles.
    sb_q.push_back(mk(2'b01, PULSE));
    p0 = pulse_cnt;
    for (int i = 0; i < 40; i++) begin
      btn = (i % 3 == 0);
      @(negedge clk);
    end
    btn = 1'b1;
    repeat (1000) @(negedge clk);
    chk("btn_one_pulse", pulse_cnt - p0, 1);
    chk("btn_cause", cause, 1);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    wait_idle(200);

    // Software reset for a distinct cause before the simultaneous test.
    sb_q.push_back(mk(2'b11, PULSE));
    sw_strobe();
    wait_idle(200);

    // Button event coincident with a software strobe: button wins.
    sb_q.push_back(mk(2'b01, PULSE));
    btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("btn_latency_early", rst_req, 0);
    sw_strobe();
    chk("btn_latency", rst_req, 1);
    repeat (30) @(negedge clk);
    chk("in_holdoff", busy & ~rst_req, 1);
    p0 = pulse_cnt;
    sw_strobe();
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("holdoff_drop_pulse", pulse_cnt - p0, 0);
    chk("holdoff_drop_cause", cause, 1);
    btn = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of a pulse.
    sb_q.push_back(mk(2'b11, 5));
    sw_strobe();
    repeat (4) @(negedge clk);
    chk("pre_abort_req", rst_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req", rst_req, 0);
    chk("abort_cause", cause, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    sb_q.push_back(mk(2'b11, PULSE));
    sw_strobe();
    wait_idle(200);
    chk("after_abort_cause", cause, 3);

`ifdef RST_REQ_WDT_EN
    // Watchdog timeout without kicks.
    sb_q.push_back(mk(2'b10, PULSE));
    wdt_limit = 100;
    wdt_en    = 1'b1;
    n = 0;
    while (!rst_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wdt_latency", n, 101);
    wdt_en = 1'b0;
    wait_idle(200);
    chk("wdt_cause", cause, 2);

    // Regular kicks keep the watchdog quiet.
    p0 = pulse_cnt;
    wdt_en = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      wdt_kick = (i % 50 == 0);
      @(negedge clk);
    end
    wdt_kick = 1'b0;
    wdt_en   = 1'b0;
    chk("wdt_kick_nopulse", pulse_cnt - p0, 0);

    // Limit 0 disables the watchdog.
    wdt_limit = 0;
    wdt_en    = 1'b1;
    repeat (300) @(negedge clk);
    wdt_en = 1'b0;
    chk("wdt_limit0_nopulse", pulse_cnt - p0, 0);
`else
    // Watchdog removed: ports are ignored.
    p0 = pulse_cnt;
    wdt_limit = 10;
    wdt_en    = 1'b1;
    repeat (1000) @(negedge clk);
    wdt_en = 1'b0;
    chk("nowdt_nopulse", pulse_cnt - p0, 0);
    chk("nowdt_cause", cause, 3);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("end_req", rst_req, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
